ray_dispatcher: RTL and testbench

//  Frame-level scheduler upstream of a bank of NUM_UNITS ray units. On start_in it latches the camera and fractal select.
//  It then scans pixels in raster order and issues one pixel per cycle (max) to a ready unit, chosen round-robin.
//  It pulses frame_done_out once every issued pixel has retired (all units ready again).

---
 rtl/ray_dispatcher_pkg.sv | 27 ++
 rtl/ray_dispatcher_rr.sv | 28 ++
 rtl/ray_dispatcher.sv | 149 ++++++++++++++
 tb/tb_ray_dispatcher.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_dispatcher_pkg.sv
// Shared types for the ray dispatcher: fixed-point vectors, dispatcher states
// and a small index-width helper.
package ray_dispatcher_pkg;

  localparam int FP_BITS      = 16;
  localparam int FRACTAL_BITS = 3;

  typedef logic signed [FP_BITS-1:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  typedef enum logic [1:0] {
    RD_Idle  = 2'd0,
    RD_Issue = 2'd1,
    RD_Drain = 2'd2
  } ray_disp_state_e;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ray_dispatcher_rr.sv
// Round-robin pick: first set bit of elig at or after ptr, wrapping cyclically.
module rr_select
  import ray_dispatcher_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_bits(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] sel
);

  int idx;

  // Scan from ptr upwards; the first eligible hit wins and later hits are ignored.
  always_comb begin
    any = 1'b0;
    sel = {IW{1'b0}};
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      sel = (!any && elig[idx]) ? IW'(idx) : sel;
      any = any | elig[idx];
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Frame scheduler: latches camera/scene on start, walks pixels in raster order and
// hands one pixel per cycle to a ready ray unit, then waits for all units to retire.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int NUM_UNITS      = 4,
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  vec3_t                   cam_origin_in,
  input  vec3_t                   cam_forward_in,
  input  logic [FRACTAL_BITS-1:0] fractal_sel_in,
  input  logic [NUM_UNITS-1:0]    ru_ready_in,
  output logic [NUM_UNITS-1:0]    ru_valid_out,
  output logic [H_BITS-1:0]       hcount_out,
  output logic [V_BITS-1:0]       vcount_out,
  output vec3_t                   ray_origin_out,
  output vec3_t                   ray_direction_out,
  output logic [FRACTAL_BITS-1:0] fractal_sel_out,
  output logic                    busy_out,
  output logic                    frame_done_out
);

  localparam int                IW     = idx_bits(NUM_UNITS);
  localparam logic [H_BITS-1:0] X_LAST = H_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [V_BITS-1:0] Y_LAST = V_BITS'(DISPLAY_HEIGHT - 1);

  ray_disp_state_e         state, state_nxt;
  logic [H_BITS-1:0]       x, x_nxt, h_nxt;
  logic [V_BITS-1:0]       y, y_nxt, v_nxt;
  logic [IW-1:0]           rr_ptr, rr_nxt, sel;
  logic [NUM_UNITS-1:0]    elig, valid_nxt;
  logic                    any, busy_nxt, done_nxt;
  vec3_t                   origin_nxt, dir_nxt;
  logic [FRACTAL_BITS-1:0] fsel_nxt;

  // A unit whose valid is still high has not yet dropped ready; never issue to it twice.
  assign elig = ru_ready_in & ~ru_valid_out;

  rr_select #(.N(NUM_UNITS), .IW(IW)) u_rr (
    .elig (elig),
    .ptr  (rr_ptr),
    .any  (any),
    .sel  (sel)
  );

  // State, counters and every output register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= RD_Idle;
      x                 <= {H_BITS{1'b0}};
      y                 <= {V_BITS{1'b0}};
      rr_ptr            <= {IW{1'b0}};
      ru_valid_out      <= {NUM_UNITS{1'b0}};
      hcount_out        <= {H_BITS{1'b0}};
      vcount_out        <= {V_BITS{1'b0}};
      ray_origin_out    <= '{default: 16'sd0};
      ray_direction_out <= '{default: 16'sd0};
      fractal_sel_out   <= {FRACTAL_BITS{1'b0}};
      busy_out          <= 1'b0;
      frame_done_out    <= 1'b0;
    end else begin
      state             <= state_nxt;
      x                 <= x_nxt;
      y                 <= y_nxt;
      rr_ptr            <= rr_nxt;
      ru_valid_out      <= valid_nxt;
      hcount_out        <= h_nxt;
      vcount_out        <= v_nxt;
      ray_origin_out    <= origin_nxt;
      ray_direction_out <= dir_nxt;
      fractal_sel_out   <= fsel_nxt;
      busy_out          <= busy_nxt;
      frame_done_out    <= done_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a branch says otherwise.
  always_comb begin
    state_nxt  = state;
    x_nxt      = x;
    y_nxt      = y;
    rr_nxt     = rr_ptr;
    valid_nxt  = {NUM_UNITS{1'b0}};
    h_nxt      = hcount_out;
    v_nxt      = vcount_out;
    origin_nxt = ray_origin_out;
    dir_nxt    = ray_direction_out;
    fsel_nxt   = fractal_sel_out;
    busy_nxt   = busy_out;
    done_nxt   = 1'b0;
    case (state)
      RD_Idle: begin
        if (start_in) begin
          origin_nxt = cam_origin_in;
          dir_nxt    = cam_forward_in;
          fsel_nxt   = fractal_sel_in;
          x_nxt      = {H_BITS{1'b0}};
          y_nxt      = {V_BITS{1'b0}};
          busy_nxt   = 1'b1;
          state_nxt  = RD_Issue;
        end else begin
          state_nxt = RD_Idle;
        end
      end
      RD_Issue: begin
        if (any) begin
          for (int i = 0; i < NUM_UNITS; i++) begin
            valid_nxt[i] = (sel == IW'(i));
          end
          h_nxt  = x;
          v_nxt  = y;
          rr_nxt = (sel == IW'(NUM_UNITS - 1)) ? {IW{1'b0}} : sel + IW'(1);
          if (x == X_LAST) begin
            x_nxt = {H_BITS{1'b0}};
            if (y == Y_LAST) begin
              y_nxt     = {V_BITS{1'b0}};
              state_nxt = RD_Drain;
            end else begin
              y_nxt = y + V_BITS'(1);
            end
          end else begin
            x_nxt = x + H_BITS'(1);
          end
        end else begin
          valid_nxt = {NUM_UNITS{1'b0}};
        end
      end
      RD_Drain: begin
        if ((ru_valid_out == {NUM_UNITS{1'b0}}) && (&ru_ready_in)) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = RD_Idle;
        end else begin
          state_nxt = RD_Drain;
        end
      end
      default: begin
        state_nxt = RD_Idle;
      end
    endcase
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher on a 4x2 frame with four units.
module tb_ray_dispatcher;
  import ray_dispatcher_pkg::*;

  localparam int NU = 4, W = 4, H = 2, HB = 4, VB = 2;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          start_in = 1'b0;
  vec3_t         cam_origin_in = '{default: 16'sd0};
  vec3_t         cam_forward_in = '{default: 16'sd0};
  logic [2:0]    fractal_sel_in = 3'd0;
  logic [NU-1:0] ru_ready_in = 4'hF;
  logic [NU-1:0] ru_valid_out;
  logic [HB-1:0] hcount_out;
  logic [VB-1:0] vcount_out;
  vec3_t         ray_origin_out, ray_direction_out;
  logic [2:0]    fractal_sel_out;
  logic          busy_out, frame_done_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  vec3_t cam_a = '{x: 16'sd100, y: 16'sd200, z: 16'sd300};
  vec3_t fwd_a = '{x: 16'sd0,   y: 16'sd0,   z: 16'sd256};
  vec3_t cam_b = '{x: -16'sd50, y: 16'sd75,  z: 16'sd9};
  vec3_t fwd_b = '{x: 16'sd181, y: 16'sd0,   z: 16'sd181};
  vec3_t cam_n = '{x: 16'sd1,   y: 16'sd2,   z: 16'sd3};

  always #5 clk_in = ~clk_in;

  ray_dispatcher #(
    .NUM_UNITS(NU), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .cam_origin_in(cam_origin_in), .cam_forward_in(cam_forward_in),
    .fractal_sel_in(fractal_sel_in), .ru_ready_in(ru_ready_in),
    .ru_valid_out(ru_valid_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .ray_origin_out(ray_origin_out), .ray_direction_out(ray_direction_out),
    .fractal_sel_out(fractal_sel_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
  );

  function automatic logic [NU+HB+VB-1:0] pix(input int p, input int unit);
    logic [NU-1:0] oh;
    oh = 4'b0001 << unit;
    return {oh, HB'(p % W), VB'(p / W)};
  endfunction

  task automatic apply_reset(input logic [NU-1:0] rdy);
    rst_in = 1'b1; start_in = 1'b0; ru_ready_in = rdy;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic start_frame(input vec3_t org, input vec3_t fwd, input logic [2:0] fs);
    cam_origin_in = org; cam_forward_in = fwd; fractal_sel_in = fs; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0; cam_origin_in = cam_n; fractal_sel_in = 3'd6;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    @(negedge clk_in); @(negedge clk_in);
    total_cnt++;
    if ({ru_valid_out, hcount_out, vcount_out, fractal_sel_out, busy_out, frame_done_out,
         ray_origin_out, ray_direction_out} !== '0)
      $display("FAIL reset_outputs valid=%b h=%0d v=%0d busy=%b done=%b want all 0",
               ru_valid_out, hcount_out, vcount_out, busy_out, frame_done_out);
    else pass_cnt++;
    rst_in = 1'b0;
  endtask

  task automatic test_raster();
    apply_reset(4'hF);
    start_frame(cam_a, fwd_a, 3'd5);
    total_cnt++;
    if ({busy_out, ru_valid_out} !== 5'b1_0000)
      $display("FAIL raster_accept busy=%b valid=%b want 1/0000", busy_out, ru_valid_out);
    else pass_cnt++;
    for (int p = 0; p < W * H; p++) begin
      @(negedge clk_in);
      total_cnt++;
      if ({ru_valid_out, hcount_out, vcount_out} !== pix(p, p % NU))
        $display("FAIL raster_issue p=%0d got %b,%0d,%0d want %h", p, ru_valid_out,
                 hcount_out, vcount_out, pix(p, p % NU));
      else pass_cnt++;
      total_cnt++;
      if ({ray_origin_out, ray_direction_out, fractal_sel_out, busy_out} !== {cam_a, fwd_a, 3'd5, 1'b1})
        $display("FAIL raster_latch p=%0d got %h want %h", p,
                 {ray_origin_out, ray_direction_out, fractal_sel_out},
                 {cam_a, fwd_a, 3'd5});
      else pass_cnt++;
    end
    @(negedge clk_in);
    total_cnt++;
    if ({ru_valid_out, frame_done_out, busy_out} !== 6'b0000_0_1)
      $display("FAIL raster_drain got %b want 000001", {ru_valid_out, frame_done_out, busy_out});
    else pass_cnt++;
    @(negedge clk_in);
    total_cnt++;
    if ({ru_valid_out, frame_done_out, busy_out} !== 6'b0000_1_0)
      $display("FAIL raster_done got %b want 000010", {ru_valid_out, frame_done_out, busy_out});
    else pass_cnt++;
    @(negedge clk_in);
    total_cnt++;
    if (frame_done_out !== 1'b0) $display("FAIL raster_done_width got %b want 0", frame_done_out);
    else pass_cnt++;
  endtask

  task automatic test_guard();
    int dly = 0, issues = 0, last = 0, dones = 0;
    bit fin = 1'b0;
    apply_reset(4'b0100);
    start_frame(cam_a, fwd_a, 3'd1);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk_in);
      if (ru_valid_out !== 4'b0000) begin
        total_cnt++;
        if ({ru_valid_out, hcount_out, vcount_out} !== pix(issues, 2))
          $display("FAIL guard_issue n=%0d got %b,%0d,%0d want %h", issues, ru_valid_out,
                   hcount_out, vcount_out, pix(issues, 2));
        else pass_cnt++;
        if (issues > 0) begin
          total_cnt++;
          if (cyc - last !== 7) $display("FAIL guard_gap n=%0d got %0d want 7", issues, cyc - last);
          else pass_cnt++;
        end
        last = cyc;
        issues++;
      end
      if (frame_done_out === 1'b1) begin dones++; fin = 1'b1; end
      if (ru_valid_out[2] === 1'b1) dly = 6;
      else if (dly > 1) begin dly--; ru_ready_in[2] = 1'b0; end
      else if (dly == 1) begin dly = 0; ru_ready_in[2] = 1'b1; end
      if (issues == W * H) begin ru_ready_in[0] = 1'b1; ru_ready_in[1] = 1'b1; ru_ready_in[3] = 1'b1; end
    end
    total_cnt++;
    if (issues !== W * H || dones !== 1)
      $display("FAIL guard_totals issues=%0d done=%0d want 8 and 1", issues, dones);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    apply_reset(4'hF);
    start_frame(cam_b, fwd_b, 3'd3);
    for (int p = 0; p < W * H; p++) begin
      if (p == 3) begin
        ru_ready_in = 4'h0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk_in);
          total_cnt++;
          if ({ru_valid_out, busy_out} !== 5'b0000_1)
            $display("FAIL stall_idle i=%0d valid=%b busy=%b want 0000/1", i, ru_valid_out, busy_out);
          else pass_cnt++;
        end
        ru_ready_in = 4'hF;
      end
      @(negedge clk_in);
      total_cnt++;
      if ({ru_valid_out, hcount_out, vcount_out} !== pix(p, p % NU))
        $display("FAIL stall_issue p=%0d got %b,%0d,%0d want %h", p, ru_valid_out,
                 hcount_out, vcount_out, pix(p, p % NU));
      else pass_cnt++;
    end
    @(negedge clk_in); @(negedge clk_in);
    total_cnt++;
    if ({frame_done_out, busy_out} !== 2'b10)
      $display("FAIL stall_done done=%b busy=%b want 1/0", frame_done_out, busy_out);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    apply_reset(4'hF);
    start_frame(cam_b, fwd_b, 3'd2);
    for (int p = 0; p < W * H; p++) begin
      start_in = (p == 2);
      cam_origin_in = cam_n; fractal_sel_in = 3'd7;
      @(negedge clk_in);
      start_in = 1'b0;
      total_cnt++;
      if ({ru_valid_out, hcount_out, vcount_out} !== pix(p, p % NU))
        $display("FAIL ign_issue p=%0d got %b,%0d,%0d want %h", p, ru_valid_out,
                 hcount_out, vcount_out, pix(p, p % NU));
      else pass_cnt++;
      total_cnt++;
      if ({ray_origin_out, fractal_sel_out, busy_out} !== {cam_b, 3'd2, 1'b1})
        $display("FAIL ign_latch p=%0d origin=%h fsel=%0d busy=%b want %h/2/1", p,
                 ray_origin_out, fractal_sel_out, busy_out, cam_b);
      else pass_cnt++;
    end
    @(negedge clk_in); @(negedge clk_in);
    total_cnt++;
    if (frame_done_out !== 1'b1) $display("FAIL ign_done got %b want 1", frame_done_out);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    apply_reset(4'hF);
    start_frame(cam_a, fwd_b, 3'd4);
    for (int p = 0; p < W * H; p++) @(negedge clk_in);
    total_cnt++;
    if ({ru_valid_out, hcount_out, vcount_out} !== pix(7, 3))
      $display("FAIL drain_last got %b,%0d,%0d want %h", ru_valid_out, hcount_out, vcount_out, pix(7, 3));
    else pass_cnt++;
    ru_ready_in = 4'b1101;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      total_cnt++;
      if ({frame_done_out, busy_out, ru_valid_out} !== 6'b0_1_0000)
        $display("FAIL drain_wait i=%0d done=%b busy=%b valid=%b want 0/1/0000", i,
                 frame_done_out, busy_out, ru_valid_out);
      else pass_cnt++;
    end
    ru_ready_in = 4'hF; start_in = 1'b1; cam_origin_in = cam_b;
    @(negedge clk_in);
    start_in = 1'b0;
    total_cnt++;
    if ({frame_done_out, busy_out, ru_valid_out} !== 6'b1_0_0000)
      $display("FAIL drain_done done=%b busy=%b valid=%b want 1/0/0000",
               frame_done_out, busy_out, ru_valid_out);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      total_cnt++;
      if ({frame_done_out, busy_out, ru_valid_out} !== 6'b0)
        $display("FAIL drain_after i=%0d done=%b busy=%b valid=%b want 0/0/0000", i,
                 frame_done_out, busy_out, ru_valid_out);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(4'hF);
    start_frame(cam_a, fwd_a, 3'd5);
    for (int p = 0; p < 3; p++) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    total_cnt++;
    if ({ru_valid_out, hcount_out, vcount_out, fractal_sel_out, busy_out, frame_done_out,
         ray_origin_out, ray_direction_out} !== '0)
      $display("FAIL rstmid_outputs valid=%b h=%0d v=%0d busy=%b done=%b want all 0",
               ru_valid_out, hcount_out, vcount_out, busy_out, frame_done_out);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      total_cnt++;
      if ({ru_valid_out, busy_out, frame_done_out} !== 6'b0)
        $display("FAIL rstmid_idle i=%0d valid=%b busy=%b done=%b want 0", i,
                 ru_valid_out, busy_out, frame_done_out);
      else pass_cnt++;
    end
    start_frame(cam_b, fwd_b, 3'd1);
    @(negedge clk_in);
    total_cnt++;
    if ({ru_valid_out, hcount_out, vcount_out, ray_origin_out} !== {pix(0, 0), cam_b})
      $display("FAIL rstmid_restart got %b,%0d,%0d origin=%h want 0001,0,0 origin=%h",
               ru_valid_out, hcount_out, vcount_out, ray_origin_out, cam_b);
    else pass_cnt++;
    apply_reset(4'hF);
  endtask

  initial begin
    test_reset();
    test_raster();
    test_guard();
    test_stall();
    test_start_ignored();
    test_drain();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
